mips_dmem_responder: RTL
========================

// Module: mips_dmem_responder
// PURPOSE
//  Data-side memory responder for the single-cycle MIPS core: the slave end of the
//  memwrite/aluout/writedata/readdata port. Decodes the byte address into a word RAM
//  and a memory-mapped I/O page: free-running timer, compare, status/error and a
//  tohost halt register. Sits beside the instruction memory in the top level.
// PARAMETERS
//  RAM_WORDS  64             number of 32-bit RAM words; must be a power of 2, >=4
//  IO_BASE    32'hFFFF_0000  base of the 16-word I/O page (addr[31:6]==IO_BASE[31:6])
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high
//  memwrite   in   1   write strobe from core
//  aluout     in   32  byte address from core
//  writedata  in   32  write data
//  readdata   out  32  read data, combinational
//  irq        out  1   = status[0] (timer match pending)
//  done       out  1   program finished (tohost written)
//  exitcode   out  32  value of first tohost write
// BEHAVIOUR
//  - Reads are zero-latency combinational (core samples in the same cycle); writes
//    commit on the rising edge when memwrite=1. Read of an address being written in
//    the same cycle returns the old value.
//  - Decode: RAM when aluout < 4*RAM_WORDS (index aluout[log2(RAM_WORDS)+1:2]);
//    I/O when in the I/O page; anything else is unmapped.
//  - I/O map (offset): 0x0 COUNT (RO), 0x4 COMPARE (RW), 0x8 STATUS,
//    0xC TOHOST (WO, reads 0). All other page offsets: read 0, write ignored, no error.
//  - COUNT: increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0; writes ignored.
//  - Match: when COUNT==COMPARE, STATUS[0] set next edge (sticky).
//  - STATUS: [0] match, [1] misaligned error, [2] unmapped error; [31:3] read 0.
//    Write: each bit written 1 is cleared (W1C). Same-cycle set and clear: set wins.
//  - Misaligned (aluout[1:0]!=0) when memwrite=1 or on a read: readdata=0, no write,
//    STATUS[1] set. Unmapped access: readdata=0, no write, STATUS[2] set. Read
//    errors are flagged only while memwrite=0 and aluout is unmapped/misaligned;
//    the core drives aluout every cycle, so the flag reflects all decoded addresses.
//  - TOHOST: first write sets done=1 and latches exitcode; later writes ignored;
//    done holds until reset.
//  - Reset values: COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, done=0, exitcode=0,
//    irq=0. RAM contents are NOT cleared. Reset mid-write: write is dropped.
//  - readdata is never X: any undecoded case drives 0.
// CONFIGURATION
//  DMEM_WRCOUNT_EN defined: adds WRCOUNT at offset 0x10, a 32-bit saturating count of
//   committed RAM writes (reset 0, holds at 32'hFFFF_FFFF); write of any value clears.
//  DMEM_WRCOUNT_EN undefined: offset 0x10 behaves like other unused offsets (reads 0).
// TESTING
//  - RAM: write 0xDEADBEEF @0x10, read @0x10 next cycle -> 0xDEADBEEF; same-cycle
//    read during write @0x10 of 0x1 -> old value 0xDEADBEEF.
//  - Timer: after reset read COUNT at cycle 5 -> 5; write COMPARE=20, cycle 21
//    -> irq=1, STATUS=1; write STATUS=1 -> irq=0 next cycle.
//  - Set/clear collision: W1C STATUS[0] on the exact match cycle -> STATUS[0] stays 1.
//  - Errors: read @0x2 -> readdata=0, STATUS[1]=1; write @0x1000 (RAM_WORDS=64)
//    -> no RAM change, STATUS[2]=1; write STATUS=6 -> STATUS=0.
//  - Halt: write TOHOST=7 then 9 -> done=1, exitcode=7; reset -> done=0,
//    exitcode=0, COUNT=0, RAM word @0x10 still 0xDEADBEEF.
//  - DMEM_WRCOUNT_EN: 3 RAM writes + 1 misaligned write -> WRCOUNT=3; without
//    macro, read @IO_BASE+0x10 -> 0.

Source files
------------

// File: rtl/mips_dmem_responder.sv
// Data-side memory responder for the single-cycle MIPS core: word RAM plus timer/status/tohost I/O page (optional WRCOUNT via DMEM_WRCOUNT_EN).
// Latency: reads are combinational in the same cycle; writes and status updates commit on the next rising edge.
// Backpressure: none, every access completes in its cycle; illegal accesses read 0, drop the write and raise a sticky STATUS flag.
module mips_dmem_responder #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        done,
    output logic [31:0] exitcode
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    localparam logic [3:0] OFF_COUNT   = 4'd0;
    localparam logic [3:0] OFF_COMPARE = 4'd1;
    localparam logic [3:0] OFF_STATUS  = 4'd2;
    localparam logic [3:0] OFF_TOHOST  = 4'd3;
`ifdef DMEM_WRCOUNT_EN
    localparam logic [3:0] OFF_WRCOUNT = 4'd4;
`endif

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   count;
    logic [31:0]   compare;
    logic [2:0]    status;
    logic [2:0]    status_nxt;
    logic [2:0]    status_clr;
    logic [31:0]   io_rdata;

    logic          misaligned;
    logic          ram_hit;
    logic          io_hit;
    logic          unmapped;
    logic          match;
    logic          io_wr;
    logic          ram_we;
    logic [3:0]    io_off;
    logic [AW-1:0] ram_idx;

    assign misaligned = (aluout[1:0] != 2'b00);
    assign ram_hit    = (aluout < RAM_BYTES);
    assign io_hit     = (aluout[31:6] == IO_BASE[31:6]);
    assign unmapped   = !ram_hit && !io_hit;
    assign io_off     = aluout[5:2];
    assign ram_idx    = aluout[AW+1:2];
    assign match      = (count == compare);

    // A write arriving while reset is asserted is dropped, including RAM.
    assign ram_we = memwrite && ram_hit && !misaligned && !reset;
    assign io_wr  = memwrite && io_hit && !ram_hit && !misaligned;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_comb begin
        status_clr = '0;
        if (io_wr && io_off == OFF_STATUS) begin
            status_clr = writedata[2:0];
        end
        status_nxt[0] = (status[0] & ~status_clr[0]) | match;
        status_nxt[1] = (status[1] & ~status_clr[1]) | misaligned;
        status_nxt[2] = (status[2] & ~status_clr[2]) | unmapped;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            compare  <= 32'hFFFF_FFFF;
            status   <= '0;
            done     <= 1'b0;
            exitcode <= '0;
        end else begin
            count  <= count + 32'd1;
            status <= status_nxt;
            if (io_wr && io_off == OFF_COMPARE) begin
                compare <= writedata;
            end
            if (io_wr && io_off == OFF_TOHOST && !done) begin
                done     <= 1'b1;
                exitcode <= writedata;
            end
        end
    end

`ifdef DMEM_WRCOUNT_EN
    logic [31:0] wrcount;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrcount <= '0;
        end else if (io_wr && io_off == OFF_WRCOUNT) begin
            wrcount <= '0;
        end else if (ram_we && wrcount != 32'hFFFF_FFFF) begin
            wrcount <= wrcount + 32'd1;
        end
    end
`endif

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_COUNT:   io_rdata = count;
            OFF_COMPARE: io_rdata = compare;
            OFF_STATUS:  io_rdata = {29'd0, status};
`ifdef DMEM_WRCOUNT_EN
            OFF_WRCOUNT: io_rdata = wrcount;
`endif
            default:     io_rdata = '0;
        endcase
    end

    always_comb begin
        readdata = '0;
        if (!misaligned) begin
            if (ram_hit) begin
                readdata = ram[ram_idx];
            end else if (io_hit) begin
                readdata = io_rdata;
            end
        end
    end

    assign irq = status[0];

endmodule
